mem_responder: RTL and testbench

//  Memory-side responder for the LC-3b read/write/mem_resp handshake used by the datapath controllers
//  (fetch, LDR/STR, LDI/STI indirect pointer). It accepts one request at a time, waits a fixed latency,

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port 16-bit word memory answering the read/write/mem_resp handshake
// after a fixed latency; writes honour byte enables, reads return a registered word.
module mem_responder #(
   parameter int LATENCY   = 4,
   parameter int ADDR_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   input  logic [1:0]  mem_byte_enable,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        proto_err
);

   // state | meaning
   // IDLE  | no transaction; request fields latched on the edge a request is seen
   // WAIT  | latency down-counter running; a dropped request aborts to IDLE
   // RESP  | mem_resp high for this one cycle; a pending write commits at its end
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t               state, state_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic [ADDR_BITS-1:0] idx_q;
   logic [15:0]          wdata_q;
   logic [1:0]           be_q;
   logic                 wr_q;

   logic [15:0]          mem_array [2**ADDR_BITS];

   logic                 req;
   logic                 accept;
   logic [ADDR_BITS-1:0] idx_req;
   logic [ADDR_BITS-1:0] rd_idx;
   logic                 rd_op;
   logic                 unused_addr;

   assign req         = mem_read | mem_write;
   assign accept      = (state == IDLE) && req;
   assign idx_req     = mem_address[ADDR_BITS:1];
   assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

   // With LATENCY==1 RESP is entered straight from IDLE, so read the live request.
   assign rd_idx = (state == IDLE) ? idx_req  : idx_q;
   assign rd_op  = (state == IDLE) ? mem_read : !wr_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               cnt_nxt   = CNT_INIT;
               state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!req) begin
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         mem_resp  <= 1'b0;
         mem_rdata <= 16'h0000;
         proto_err <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= 16'h0000;
         be_q      <= 2'b00;
         wr_q      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         mem_resp <= (state_nxt == RESP);
         if ((state_nxt == RESP) && rd_op) begin
            mem_rdata <= mem_array[rd_idx];
         end
         if (accept) begin
            idx_q   <= idx_req;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            // read wins when both strobes are high
            wr_q    <= !mem_read;
            if (mem_read && mem_write) begin
               proto_err <= 1'b1;
            end
         end
      end
   end

   // Storage is deliberately not reset; a reset before RESP leaves it untouched.
   always_ff @(posedge clk) begin
      if ((state == RESP) && wr_q) begin
         if (be_q[0]) begin
            mem_array[idx_q][7:0] <= wdata_q[7:0];
         end
         if (be_q[1]) begin
            mem_array[idx_q][15:8] <= wdata_q[15:8];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 and a LATENCY=1 instance,
// expected read data queued at request time and compared at mem_resp.
module tb_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        mem_read        [2];
   logic        mem_write       [2];
   logic [15:0] mem_address     [2];
   logic [15:0] mem_wdata       [2];
   logic [1:0]  mem_byte_enable [2];
   logic        mem_resp        [2];
   logic [15:0] mem_rdata       [2];
   logic        proto_err       [2];

   int          checks = 0;
   int          passes = 0;
   logic [15:0] model [2][256];
   logic [15:0] exp_q [$];
   logic [15:0] rd_val;

   mem_responder #(.LATENCY(4), .ADDR_BITS(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read[0]),
      .mem_write       (mem_write[0]),
      .mem_address     (mem_address[0]),
      .mem_wdata       (mem_wdata[0]),
      .mem_byte_enable (mem_byte_enable[0]),
      .mem_resp        (mem_resp[0]),
      .mem_rdata       (mem_rdata[0]),
      .proto_err       (proto_err[0])
   );

   mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read[1]),
      .mem_write       (mem_write[1]),
      .mem_address     (mem_address[1]),
      .mem_wdata       (mem_wdata[1]),
      .mem_byte_enable (mem_byte_enable[1]),
      .mem_resp        (mem_resp[1]),
      .mem_rdata       (mem_rdata[1]),
      .proto_err       (proto_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drop(input int sel);
      mem_read[sel]        = 1'b0;
      mem_write[sel]       = 1'b0;
      mem_address[sel]     = 16'h0000;
      mem_wdata[sel]       = 16'h0000;
      mem_byte_enable[sel] = 2'b00;
   endtask

   // One complete transaction; request fields are scrambled while waiting
   // so that only the values present at accept may matter.
   task automatic do_req(input int sel, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, output logic [15:0] rdata_o);
      int          lat;
      int          idx;
      int          n;
      bit          got;
      logic [15:0] exp;
      lat = (sel == 1) ? 1 : 4;
      idx = int'(addr[8:1]);
      n   = 0;
      got = 0;
      @(negedge clk);
      chk($sformatf("resp_idle%0d", sel), mem_resp[sel], 1'b0);
      mem_read[sel]        = rd;
      mem_write[sel]       = wr;
      mem_address[sel]     = addr;
      mem_wdata[sel]       = wdata;
      mem_byte_enable[sel] = be;
      if (rd) begin
         exp_q.push_back(model[sel][idx]);
      end else if (wr) begin
         if (be[0]) model[sel][idx][7:0]  = wdata[7:0];
         if (be[1]) model[sel][idx][15:8] = wdata[15:8];
      end
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (mem_resp[sel]) begin
            got = 1;
         end else begin
            mem_address[sel]     = ~addr;
            mem_wdata[sel]       = ~wdata;
            mem_byte_enable[sel] = ~be;
         end
      end
      chk($sformatf("resp_seen%0d", sel), {31'd0, got}, 32'd1);
      chk($sformatf("latency%0d", sel), n, lat);
      if (rd) begin
         exp = exp_q.pop_front();
         if (got) chk($sformatf("rdata%0d@%04h", sel, addr), mem_rdata[sel], exp);
      end
      rdata_o = mem_rdata[sel];
      drop(sel);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drop(0);
      drop(1);
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_resp%0d", s), mem_resp[s], 1'b0);
         chk($sformatf("rst_rdata%0d", s), mem_rdata[s], 16'h0000);
         chk($sformatf("rst_perr%0d", s), proto_err[s], 1'b0);
      end
      rst_n = 1'b1;

      // Write then read with the nominal latency
      do_req(0, 1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, rd_val);

      // Reset in the middle of a pending write leaves memory untouched
      do_req(0, 1'b0, 1'b1, 16'h0010, 16'h1111, 2'b11, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, rd_val);
      @(negedge clk);
      mem_write[0]       = 1'b1;
      mem_address[0]     = 16'h0010;
      mem_wdata[0]       = 16'hBEEF;
      mem_byte_enable[0] = 2'b11;
      @(negedge clk);
      chk("mid_wait_resp", mem_resp[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_resp", mem_resp[0], 1'b0);
      chk("arst_perr", proto_err[0], 1'b0);
      chk("arst_rdata", mem_rdata[0], 16'h0000);
      drop(0);
      @(negedge clk);
      rst_n = 1'b1;
      do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, rd_val);

      // Byte enables, including an all-zero enable
      do_req(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA, 2'b11, rd_val);
      do_req(0, 1'b0, 1'b1, 16'h0030, 16'h5566, 2'b01, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, rd_val);
      chk("be01_word", rd_val, 16'hAA66);
      do_req(0, 1'b0, 1'b1, 16'h0030, 16'h7700, 2'b10, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, rd_val);
      chk("be10_word", rd_val, 16'h7766);
      do_req(0, 1'b0, 1'b1, 16'h0030, 16'hFFFF, 2'b00, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, rd_val);

      // Odd byte address selects the same word
      do_req(0, 1'b0, 1'b1, 16'h0060, 16'h1111, 2'b11, rd_val);
      do_req(0, 1'b0, 1'b1, 16'h0061, 16'h22CC, 2'b10, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0061, 16'h0000, 2'b00, rd_val);
      chk("odd_addr_word", rd_val, 16'h2211);

      // Abort: read held for two cycles then dropped
      @(negedge clk);
      mem_read[0]    = 1'b1;
      mem_address[0] = 16'h0020;
      @(negedge clk);
      chk("abort_c1_resp", mem_resp[0], 1'b0);
      @(negedge clk);
      drop(0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_resp", mem_resp[0], 1'b0);
      end
      do_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, rd_val);

      // Address aliasing above the index bits
      do_req(0, 1'b0, 1'b1, 16'h0002, 16'h3000, 2'b11, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0202, 16'h0000, 2'b00, rd_val);
      chk("alias_word", rd_val, 16'h3000);

      // Indirect: pointer read, then read through the returned pointer
      do_req(0, 1'b0, 1'b1, 16'h0040, 16'h0050, 2'b11, rd_val);
      do_req(0, 1'b0, 1'b1, 16'h0050, 16'hCAFE, 2'b11, rd_val);
      do_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, rd_val);
      do_req(0, 1'b1, 1'b0, rd_val, 16'h0000, 2'b00, rd_val);
      chk("indirect_word", rd_val, 16'hCAFE);

      // Read and write together: flagged, served as a read, memory unchanged
      chk("perr_before", proto_err[0], 1'b0);
      do_req(0, 1'b1, 1'b1, 16'h0020, 16'hDEAD, 2'b11, rd_val);
      chk("perr_set", proto_err[0], 1'b1);
      do_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, rd_val);
      chk("perr_sticky", proto_err[0], 1'b1);
      chk("perr_other_inst", proto_err[1], 1'b0);

      // Single-cycle latency instance, back-to-back read after write
      do_req(1, 1'b0, 1'b1, 16'h000A, 16'h5A5A, 2'b11, rd_val);
      do_req(1, 1'b1, 1'b0, 16'h000A, 16'h0000, 2'b00, rd_val);
      do_req(1, 1'b0, 1'b1, 16'h000A, 16'hC3C3, 2'b01, rd_val);
      do_req(1, 1'b1, 1'b0, 16'h000A, 16'h0000, 2'b00, rd_val);
      chk("lat1_be01_word", rd_val, 16'h5AC3);
      @(negedge clk);
      chk("lat1_resp_single", mem_resp[1], 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
